frame_tx_scheduler: RTL and testbench
=====================================

# frame_tx_scheduler

Transmit-side frame queue and scheduler between the user-input logic (DIP switches, keypad payload, add/send buttons) and the four EndDevice transmit ports. It assembles 16-bit frames on each add pulse and holds them in a 4-entry circular FIFO. On a send pulse it drains the queued frames in order, one 1-cycle `frame_tx_valid` pulse per frame. A per-port hold timer guarantees a port never receives a new frame while it is still serializing the previous one.

## Interface
- `DEPTH`, 4, FIFO entries; power of two.
- `NUM_PORTS`, 4, EndDevice ports.
- `PORT_HOLD`, 24, cycles a port stays blocked after an issue; must be ≥ 16 (frame bits) plus switch latency.

- `FPGA_CLK`  in  1  system clock.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `add_pulse`  in  1  1-cycle enqueue request (already edge-detected).
- `send_pulse`  in  1  1-cycle drain request (already edge-detected).
- `dst_addr`  in  4  destination MAC for the frame being added.
- `src_addr`  in  4  source MAC: A/B/C/D map to ports 0..3.
- `payload`  in  4  payload nibble.
- `frame_to_send`  out  NUM_PORTS*16  per-port frame, port p at bits [16p+15:16p]; holds its last value.
- `frame_tx_valid`  out  NUM_PORTS  per-port 1-cycle issue strobe.
- `queue_count`  out  3  occupied entries, 0..DEPTH.
- `queue_full`  out  1  `queue_count == DEPTH`.
- `drain_busy`  out  1  high while state is DRAIN.
- `drop_pulse`  out  1  1-cycle strobe; an add was rejected.

## Operation
- Frame format: {SFD=4'b0101, dst_addr, src_addr, payload}. The port index is stored alongside each entry.
- **Enqueue:** on `add_pulse` with `queue_full`=0 and `src_addr` in {A,B,C,D}, write the entry at `wr_ptr` and advance `wr_ptr` modulo DEPTH.
- **Rejected add:** `add_pulse` while full, or with an invalid `src_addr`, writes nothing. `drop_pulse`=1 next cycle and the FIFO is unchanged.
- **Full is registered:** "full" is judged on the registered count. An add in the same cycle as a pop while full is still dropped.
- **State IDLE:** `send_pulse` with `queue_count`>0 loads `drain_left` ← `queue_count` and moves to DRAIN. `send_pulse` with `queue_count`=0 stays in IDLE.
- **State DRAIN:** each cycle, examine the head entry (port p).
  - If `hold_cnt[p]`=0: issue it. `frame_to_send[p]` ← head frame, `frame_tx_valid[p]` ← 1, `hold_cnt[p]` ← PORT_HOLD, advance `rd_ptr`, and `drain_left` decrements.
  - Otherwise: wait. Order is strict FIFO and head-of-line blocking is accepted.
- **Leaving DRAIN:** after the issue that brings `drain_left` to 0, return to IDLE.
- **Snapshot:** only frames present at `send_pulse` are drained. Frames added during DRAIN remain queued for the next send.
- **send during DRAIN:** `send_pulse` while in DRAIN is ignored.
- **Simultaneous add and pop:** both take effect and `queue_count` is unchanged.
- **Hold timers:** each `hold_cnt` decrements by 1 per cycle while nonzero, saturating at 0, independent of state.
- **Reset values:** all pointers, counters, `hold_cnt` and state (IDLE) clear. All `frame_tx_valid`=0, `frame_to_send`=0, `queue_count`=0, `queue_full`=0, `drain_busy`=0, `drop_pulse`=0.
- **Reset mid-drain:** queued frames are discarded and no partial strobe is emitted.

## Timing
- `send_pulse` high in cycle N → `drain_busy`=1 from N+1. The first `frame_tx_valid` is high in cycle N+2, provided its port is free.
- Consecutive frames to different free ports issue on consecutive cycles.
- Two frames to the same port: the second strobe comes exactly PORT_HOLD cycles after the first.
- `add_pulse` in cycle N → `queue_count` is updated in N+1. `drop_pulse`, when raised, is also high in N+1.
- `frame_tx_valid` is high for exactly 1 cycle per issued frame. At most one port strobes per cycle.
- `drain_busy` falls in the cycle after the last issue.

## Structure
- **Shared package `l2sim_pkg`:** `SFD`, `MAC_A`..`MAC_D`, `FRAME_W`=16, `NUM_PORTS`, and a `mac_to_port` function returning a 2-bit index plus a valid bit. This package is shared with the top level and EndDevice.
- **Sub-module `port_hold_timer`:** one instance per port. Has a load input and a busy output, and holds a counter wide enough for PORT_HOLD.
- **Top body:** FIFO storage, the pointers/count, and the two-state FSM live in `frame_tx_scheduler` itself.

## Test plan
- **Basic enqueue/drain:** add one frame with src=A, dst=C, payload=7, then send → `frame_tx_valid[0]` pulses once with `frame_to_send[15:0]`=16'h5CA7, and `queue_count` goes 1→0.
- **Mixed ports:** add frames with src=A, B, C, D, then send → strobes on ports 0,1,2,3 in cycles N+2..N+5, each for 1 cycle.
- **Same-port spacing:** add 3 frames with src=B, then send → port 1 strobes at N+2, N+2+24 and N+2+48; `drain_busy` falls the cycle after the last strobe.
- **Overflow and invalid source:**
  - Add 5 frames → the 5th gives `drop_pulse`=1, `queue_count` stays 4, `queue_full`=1.
  - Add with src=4'h3 → `drop_pulse`=1.
- **Add during drain:** queue 2 frames with src=A, send, then add 1 frame with src=C during the hold wait → only the 2 original frames issue and `queue_count` ends at 1. A second send then issues the src=C frame. A `send_pulse` issued mid-drain is ignored.
- **Reset mid-drain:** assert `sys_rst` mid-drain → all outputs go to 0 immediately (asynchronous). After release, a send issues nothing.

Source files
------------

// File: rtl/l2sim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2sim_pkg
// Description : Shared L2 simulator constants, frame/queue types and the
//               MAC-to-port mapping used by the scheduler and EndDevice.
// Revision    : 1.0 - initial release
// ============================================================================
package l2sim_pkg;

  localparam int FRAME_W   = 16;
  localparam int NUM_PORTS = 4;

  localparam logic [3:0] SFD   = 4'b0101;
  localparam logic [3:0] MAC_A = 4'hA;
  localparam logic [3:0] MAC_B = 4'hB;
  localparam logic [3:0] MAC_C = 4'hC;
  localparam logic [3:0] MAC_D = 4'hD;

  typedef struct packed {
    logic       valid;
    logic [1:0] port;
  } port_sel_t;

  typedef struct packed {
    logic [1:0]         port;
    logic [FRAME_W-1:0] frame;
  } q_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  // Source MAC A..D selects EndDevice port 0..3; anything else is invalid.
  function automatic port_sel_t mac_to_port(input logic [3:0] mac);
    port_sel_t sel;
    sel.valid = 1'b1;
    sel.port  = 2'd0;
    case (mac)
      MAC_A:   sel.port = 2'd0;
      MAC_B:   sel.port = 2'd1;
      MAC_C:   sel.port = 2'd2;
      MAC_D:   sel.port = 2'd3;
      default: sel.valid = 1'b0;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_scheduler_if
// Description : User-input side requests and per-port transmit outputs of
//               the frame scheduler, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_tx_scheduler_if #(
  parameter int NUM_PORTS = 4
);
  import l2sim_pkg::*;

  logic                         add_pulse;
  logic                         send_pulse;
  logic [3:0]                   dst_addr;
  logic [3:0]                   src_addr;
  logic [3:0]                   payload;
  logic [NUM_PORTS*FRAME_W-1:0] frame_to_send;
  logic [NUM_PORTS-1:0]         frame_tx_valid;
  logic [2:0]                   queue_count;
  logic                         queue_full;
  logic                         drain_busy;
  logic                         drop_pulse;

  modport master (
    output add_pulse, send_pulse, dst_addr, src_addr, payload,
    input  frame_to_send, frame_tx_valid, queue_count, queue_full,
           drain_busy, drop_pulse
  );

  modport slave (
    input  add_pulse, send_pulse, dst_addr, src_addr, payload,
    output frame_to_send, frame_tx_valid, queue_count, queue_full,
           drain_busy, drop_pulse
  );

endinterface
`default_nettype wire

// File: rtl/port_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : port_hold_timer
// Description : Per-port blocking timer; keeps a port busy while the frame
//               last issued to it is still being serialized.
// Revision    : 1.0 - initial release
// ============================================================================
module port_hold_timer #(
  parameter int PORT_HOLD = 24
) (
  input  wire logic FPGA_CLK,
  input  wire logic sys_rst,
  input  wire logic load,
  output logic      busy
);

  localparam int CNT_W = $clog2(PORT_HOLD + 1);
  // The strobe cycle itself is the first blocked cycle, so reloading with
  // PORT_HOLD-1 puts the next strobe exactly PORT_HOLD cycles later.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PORT_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  // Reload on issue, otherwise count down and saturate at zero.
  always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
    if (sys_rst) begin
      hold_cnt <= '0;
    end else if (load) begin
      hold_cnt <= RELOAD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end

  assign busy = (hold_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/frame_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_scheduler
// Description : 4-entry transmit frame FIFO with a snapshot drain FSM that
//               issues frames in order to EndDevice ports, respecting a
//               per-port hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_scheduler #(
  parameter int DEPTH     = 4,
  parameter int NUM_PORTS = 4,
  parameter int PORT_HOLD = 24
) (
  input  wire logic           FPGA_CLK,
  input  wire logic           sys_rst,
  frame_tx_scheduler_if.slave bus
);
  import l2sim_pkg::*;

  localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);

  q_entry_t                          fifo_mem [DEPTH];
  logic [PTR_W-1:0]                  wr_ptr;
  logic [PTR_W-1:0]                  rd_ptr;
  logic [2:0]                        count;
  logic [2:0]                        drain_left;
  sched_state_t                      state;
  sched_state_t                      state_nxt;
  port_sel_t                         src_sel;
  q_entry_t                          head;
  logic                              full;
  logic                              push;
  logic                              pop;
  logic                              load_drain;
  logic [NUM_PORTS-1:0]              port_busy;
  logic [NUM_PORTS-1:0]              port_load;
  logic [NUM_PORTS-1:0]              valid_q;
  logic [NUM_PORTS-1:0][FRAME_W-1:0] frame_q;
  logic                              drop_q;

  assign src_sel = mac_to_port(bus.src_addr);
  assign head    = fifo_mem[rd_ptr];
  // Full is judged on the registered count, so a pop in the same cycle
  // does not make room for a simultaneous add.
  assign full    = (count == DEPTH_CNT);
  assign push    = bus.add_pulse && !full && src_sel.valid;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign port_load[g] = pop && (head.port == 2'(g));

    port_hold_timer #(
      .PORT_HOLD (PORT_HOLD)
    ) u_hold (
      .FPGA_CLK (FPGA_CLK),
      .sys_rst  (sys_rst),
      .load     (port_load[g]),
      .busy     (port_busy[g])
    );
  end

  // Accepted frames are assembled and written at the write pointer.
  always_ff @(posedge FPGA_CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{port:  src_sel.port,
                            frame: {SFD, bus.dst_addr, bus.src_addr, bus.payload}};
    end
  end

  // Circular pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // State register and the snapshot of frames to drain.
  always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      drain_left <= '0;
    end else begin
      state <= state_nxt;
      if (load_drain) begin
        drain_left <= count;
      end else if (pop) begin
        drain_left <= drain_left - 3'd1;
      end
    end
  end

  // Next state and issue decision. DRAIN lingers one cycle after the last
  // issue so drain_busy covers the final strobe.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load_drain = 1'b0;
    case (state)
      IDLE: begin
        if (bus.send_pulse && (count != 3'd0)) begin
          state_nxt  = DRAIN;
          load_drain = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_left == 3'd0) begin
          state_nxt = IDLE;
        end else if (!port_busy[head.port]) begin
          pop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered per-port outputs and the rejected-add strobe.
  always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
    if (sys_rst) begin
      valid_q <= '0;
      frame_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= port_load;
      drop_q  <= bus.add_pulse && !push;
      if (pop) frame_q[head.port] <= head.frame;
    end
  end

  assign bus.frame_to_send  = frame_q;
  assign bus.frame_tx_valid = valid_q;
  assign bus.queue_count    = count;
  assign bus.queue_full     = full;
  assign bus.drain_busy     = (state == DRAIN);
  assign bus.drop_pulse     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_tx_scheduler
// Description : Self-checking bench for frame_tx_scheduler: table-driven
//               adds plus a timing-aware scoreboard of issued frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_tx_scheduler;
  import l2sim_pkg::*;

  localparam int HOLD = 24;

  typedef struct {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [3:0]  pay;
    bit          exp_drop;
    int          exp_count;
    bit          exp_full;
    logic [1:0]  exp_port;
    logic [15:0] exp_frame;
  } row_t;

  typedef struct {
    logic [1:0]  port;
    logic [15:0] frame;
    int          cyc;
    bit          sched;
  } sb_t;

  logic FPGA_CLK = 1'b0;
  logic sys_rst  = 1'b1;
  int   cyc      = 0;
  int   total    = 0;
  int   bad      = 0;
  row_t rows [19];
  sb_t  exp_q [$];
  int   free_at [4];

  frame_tx_scheduler_if #(.NUM_PORTS(4)) bus ();

  frame_tx_scheduler #(
    .DEPTH     (4),
    .NUM_PORTS (4),
    .PORT_HOLD (HOLD)
  ) dut (
    .FPGA_CLK (FPGA_CLK),
    .sys_rst  (sys_rst),
    .bus      (bus)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  always @(posedge FPGA_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge FPGA_CLK);
    #1;
  endtask

  // Scoreboard consumer: every strobe must match the head of the expected queue.
  always @(negedge FPGA_CLK) begin
    int  p;
    sb_t e;
    if (!sys_rst && bus.frame_tx_valid != 4'b0) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (bus.frame_tx_valid[i]) p = i;
      check("strobe_onehot", $countones(bus.frame_tx_valid), 1);
      if (exp_q.size() == 0 || !exp_q[0].sched) begin
        check("unexpected_strobe", bus.frame_tx_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_port", p, e.port);
        check("strobe_frame", bus.frame_to_send[p*16 +: 16], e.frame);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  // Reference timing: strict FIFO order, first issue at N+2, a port reusable
  // HOLD cycles after its previous strobe, at most one strobe per cycle.
  task automatic schedule(input int n, output int fall);
    int t;
    int ti;
    t    = n + 2;
    fall = -1;
    foreach (exp_q[i]) begin
      if (!exp_q[i].sched) begin
        ti = (free_at[exp_q[i].port] > t) ? free_at[exp_q[i].port] : t;
        exp_q[i].cyc   = ti;
        exp_q[i].sched = 1'b1;
        free_at[exp_q[i].port] = ti + HOLD;
        t    = ti + 1;
        fall = ti + 1;
      end
    end
  endtask

  task automatic apply_row(input row_t r);
    tick();
    bus.add_pulse = 1'b1;
    bus.src_addr  = r.src;
    bus.dst_addr  = r.dst;
    bus.payload   = r.pay;
    tick();
    bus.add_pulse = 1'b0;
    @(negedge FPGA_CLK);
    check("drop_pulse", bus.drop_pulse, r.exp_drop);
    check("queue_count", bus.queue_count, r.exp_count);
    check("queue_full", bus.queue_full, r.exp_full);
    if (!r.exp_drop) exp_q.push_back('{r.exp_port, r.exp_frame, 0, 1'b0});
  endtask

  task automatic start_send(output int fall);
    int n;
    tick();
    bus.send_pulse = 1'b1;
    n = cyc;
    schedule(n, fall);
    tick();
    bus.send_pulse = 1'b0;
    @(negedge FPGA_CLK);
    check("drain_busy_rise", bus.drain_busy, 1);
  endtask

  task automatic wait_drain(input int exp_fall);
    int i;
    i = 0;
    @(negedge FPGA_CLK);
    while (bus.drain_busy && i < 400) begin
      @(negedge FPGA_CLK);
      i++;
    end
    check("drain_busy_fall_cycle", cyc, exp_fall);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_frames"}, bus.frame_to_send, 64'h0);
    check({name, "_valid"}, bus.frame_tx_valid, 0);
    check({name, "_count"}, bus.queue_count, 0);
    check({name, "_full"}, bus.queue_full, 0);
    check({name, "_busy"}, bus.drain_busy, 0);
    check({name, "_drop"}, bus.drop_pulse, 0);
  endtask

  initial begin
    int fall;
    rows[0]  = '{4'hA, 4'hC, 4'h7, 1'b0, 1, 1'b0, 2'd0, 16'h5CA7};
    rows[1]  = '{4'hA, 4'hB, 4'h1, 1'b0, 1, 1'b0, 2'd0, 16'h5BA1};
    rows[2]  = '{4'hB, 4'hC, 4'h2, 1'b0, 2, 1'b0, 2'd1, 16'h5CB2};
    rows[3]  = '{4'hC, 4'hD, 4'h3, 1'b0, 3, 1'b0, 2'd2, 16'h5DC3};
    rows[4]  = '{4'hD, 4'hA, 4'h4, 1'b0, 4, 1'b1, 2'd3, 16'h5AD4};
    rows[5]  = '{4'h3, 4'hA, 4'h0, 1'b1, 0, 1'b0, 2'd0, 16'h0000};
    rows[6]  = '{4'hA, 4'hD, 4'h8, 1'b0, 1, 1'b0, 2'd0, 16'h5DA8};
    rows[7]  = '{4'hB, 4'hA, 4'h9, 1'b0, 2, 1'b0, 2'd1, 16'h5AB9};
    rows[8]  = '{4'hA, 4'hC, 4'hE, 1'b0, 3, 1'b0, 2'd0, 16'h5CAE};
    rows[9]  = '{4'hC, 4'hB, 4'hF, 1'b0, 4, 1'b1, 2'd2, 16'h5BCF};
    rows[10] = '{4'hD, 4'hC, 4'h5, 1'b1, 4, 1'b1, 2'd3, 16'h0000};
    rows[11] = '{4'hB, 4'hA, 4'h1, 1'b0, 1, 1'b0, 2'd1, 16'h5AB1};
    rows[12] = '{4'hB, 4'hC, 4'h2, 1'b0, 2, 1'b0, 2'd1, 16'h5CB2};
    rows[13] = '{4'hB, 4'hD, 4'h3, 1'b0, 3, 1'b0, 2'd1, 16'h5DB3};
    rows[14] = '{4'hA, 4'hB, 4'h6, 1'b0, 1, 1'b0, 2'd0, 16'h5BA6};
    rows[15] = '{4'hA, 4'hC, 4'h7, 1'b0, 2, 1'b0, 2'd0, 16'h5CA7};
    rows[16] = '{4'hC, 4'hA, 4'h9, 1'b0, 2, 1'b0, 2'd2, 16'h5AC9};
    rows[17] = '{4'hA, 4'hB, 4'h1, 1'b0, 1, 1'b0, 2'd0, 16'h5BA1};
    rows[18] = '{4'hA, 4'hB, 4'h2, 1'b0, 2, 1'b0, 2'd0, 16'h5BA2};
    for (int p = 0; p < 4; p++) free_at[p] = 0;

    bus.add_pulse  = 1'b0;
    bus.send_pulse = 1'b0;
    bus.src_addr   = 4'h0;
    bus.dst_addr   = 4'h0;
    bus.payload    = 4'h0;

    // Reset state
    repeat (3) tick();
    @(negedge FPGA_CLK);
    check_idle_outputs("reset");
    tick();
    sys_rst = 1'b0;

    // Basic enqueue/drain
    apply_row(rows[0]);
    start_send(fall);
    wait_drain(fall);
    check("basic_count_after", bus.queue_count, 0);

    // Mixed ports, ending full
    repeat (30) tick();
    for (int i = 1; i <= 4; i++) apply_row(rows[i]);
    start_send(fall);
    wait_drain(fall);
    check("mixed_count_after", bus.queue_count, 0);

    // Invalid source, overflow, and add-while-full during first pop
    repeat (30) tick();
    for (int i = 5; i <= 10; i++) apply_row(rows[i]);
    start_send(fall);
    bus.add_pulse = 1'b1;
    bus.src_addr  = 4'hB;
    bus.dst_addr  = 4'hA;
    bus.payload   = 4'h0;
    tick();
    bus.add_pulse = 1'b0;
    @(negedge FPGA_CLK);
    check("add_during_pop_drop", bus.drop_pulse, 1);
    check("add_during_pop_count", bus.queue_count, 3);
    wait_drain(fall);
    check("overflow_count_after", bus.queue_count, 0);

    // Same-port spacing
    repeat (30) tick();
    for (int i = 11; i <= 13; i++) apply_row(rows[i]);
    start_send(fall);
    wait_drain(fall);

    // Add during drain and an ignored mid-drain send
    repeat (30) tick();
    for (int i = 14; i <= 15; i++) apply_row(rows[i]);
    start_send(fall);
    repeat (2) tick();
    apply_row(rows[16]);
    tick();
    bus.send_pulse = 1'b1;
    tick();
    bus.send_pulse = 1'b0;
    @(negedge FPGA_CLK);
    check("busy_after_ignored_send", bus.drain_busy, 1);
    wait_drain(fall);
    check("snapshot_count_left", bus.queue_count, 1);
    start_send(fall);
    wait_drain(fall);
    check("second_send_count", bus.queue_count, 0);

    // Reset mid-drain
    repeat (30) tick();
    for (int i = 17; i <= 18; i++) apply_row(rows[i]);
    start_send(fall);
    repeat (2) tick();
    #2 sys_rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    for (int p = 0; p < 4; p++) free_at[p] = 0;
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    bus.send_pulse = 1'b1;
    tick();
    bus.send_pulse = 1'b0;
    @(negedge FPGA_CLK);
    check("empty_send_busy", bus.drain_busy, 0);
    repeat (30) tick();
    @(negedge FPGA_CLK);
    check("post_reset_count", bus.queue_count, 0);
    check("post_reset_scoreboard", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
